// File: rtl/avalon_timer_pkg.sv
// Shared register-map constants and CTRL field layout for the avalon_timer_mc block.
// The optional prescaler is enabled with the AVALON_TIMER_PRESCALER_EN macro.
package avalon_timer_pkg;

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_THRESH = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_PEND    = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_IE      = 3;

  localparam int CTRL_PS_LSB = 8;
  localparam int CTRL_PS_W   = 8;

  function automatic logic [31:0] pack_ctrl(input logic en, input logic pend,
                                            input logic oneshot, input logic ie,
                                            input logic [CTRL_PS_W-1:0] ps);
    logic [31:0] v;
    v = 32'd0;
    v[CTRL_EN]      = en;
    v[CTRL_PEND]    = pend;
    v[CTRL_ONESHOT] = oneshot;
    v[CTRL_IE]      = ie;
    v[CTRL_PS_LSB +: CTRL_PS_W] = ps;
    return v;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: LOAD/THRESH/CTRL/COUNT registers, tick generation, wrap/pending, PWM output.
// AVALON_TIMER_PRESCALER_EN adds a per-channel 8-bit prescaler in CTRL[15:8].
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        out_th,
  output logic        irq_req
);

  logic [CNT_W-1:0] load_r, thresh_r, count_r;
  logic en_r, pend_r, oneshot_r, ie_r, out_th_r;
  logic wr_load_s, wr_thresh_s, wr_ctrl_s, wr_count_s;
  logic tick_s, wrap_s, unused_wdata_s;
  logic [CTRL_PS_W-1:0] ps_s;

  assign wr_load_s      = wr_en && (reg_sel == REG_LOAD);
  assign wr_thresh_s    = wr_en && (reg_sel == REG_THRESH);
  assign wr_ctrl_s      = wr_en && (reg_sel == REG_CTRL);
  assign wr_count_s     = wr_en && (reg_sel == REG_COUNT);
  assign wrap_s         = tick_s && (count_r == load_r);
  assign unused_wdata_s = ^wdata;

`ifdef AVALON_TIMER_PRESCALER_EN
  logic [CTRL_PS_W-1:0] ps_r, pcnt_r;
  logic en_rise_s;

  assign en_rise_s = wr_ctrl_s && wdata[CTRL_EN] && !en_r;
  // >= rather than == so lowering PS mid-run cannot strand the divider
  assign tick_s    = en_r && (pcnt_r >= ps_r);
  assign ps_s      = ps_r;

  // Prescaler field and divider counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_r   <= 8'd0;
      pcnt_r <= 8'd0;
    end else begin
      if (wr_ctrl_s) ps_r <= wdata[CTRL_PS_LSB +: CTRL_PS_W];
      if (wr_count_s || en_rise_s || tick_s) pcnt_r <= 8'd0;
      else if (en_r)                         pcnt_r <= pcnt_r + 8'd1;
    end
  end
`else
  assign tick_s = en_r;
  assign ps_s   = 8'd0;
`endif

  // Channel registers; software COUNT/CTRL writes take priority over the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_r    <= '0;
      thresh_r  <= '0;
      count_r   <= '0;
      en_r      <= 1'b0;
      pend_r    <= 1'b0;
      oneshot_r <= 1'b0;
      ie_r      <= 1'b0;
      out_th_r  <= 1'b0;
    end else begin
      if (wr_load_s)   load_r   <= wdata[CNT_W-1:0];
      if (wr_thresh_s) thresh_r <= wdata[CNT_W-1:0];

      if (wr_count_s)  count_r <= wdata[CNT_W-1:0];
      else if (wrap_s) count_r <= oneshot_r ? count_r : '0;
      else if (tick_s) count_r <= count_r + CNT_W'(1);

      if (wr_ctrl_s) begin
        en_r      <= wdata[CTRL_EN];
        oneshot_r <= wdata[CTRL_ONESHOT];
        ie_r      <= wdata[CTRL_IE];
      end else if (wrap_s && oneshot_r) begin
        en_r <= 1'b0;
      end

      if (wrap_s)                             pend_r <= 1'b1;
      else if (wr_ctrl_s && wdata[CTRL_PEND]) pend_r <= 1'b0;

      out_th_r <= en_r && (count_r < thresh_r);
    end
  end

  // Register read mux for this channel
  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      REG_LOAD:   rdata = 32'(load_r);
      REG_THRESH: rdata = 32'(thresh_r);
      REG_CTRL:   rdata = pack_ctrl(en_r, pend_r, oneshot_r, ie_r, ps_s);
      REG_COUNT:  rdata = 32'(count_r);
      default:    rdata = 32'd0;
    endcase
  end

  assign out_th  = out_th_r;
  assign irq_req = pend_r & ie_r;

endmodule

// File: rtl/avalon_timer_mc.sv
// Multi-channel Avalon-MM timer: address decode, registered read mux, irq OR over channels.
// Optional prescaler per channel via AVALON_TIMER_PRESCALER_EN (see timer_channel).
module avalon_timer_mc
  import avalon_timer_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 32,
  localparam int AW     = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chipselect,
  input  logic [AW-1:0]     address,
  input  logic              write,
  input  logic              read,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] out_th
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   ch_s;
  logic [1:0]        reg_s;
  logic [31:0]       ch_rdata_s [NUM_CH];
  logic [NUM_CH-1:0] irq_req_s;
  logic [31:0]       rd_mux_s, readdata_r;

  assign reg_s = address[1:0];

  generate
    if (NUM_CH > 1) begin : g_multi
      assign ch_s = address[AW-1:2];
    end else begin : g_single
      assign ch_s = 1'b0;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_channel #(.CNT_W(CNT_W)) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (chipselect && write && (ch_s == CH_W'(i))),
        .reg_sel (reg_s),
        .wdata   (writedata),
        .rdata   (ch_rdata_s[i]),
        .out_th  (out_th[i]),
        .irq_req (irq_req_s[i])
      );
    end
  endgenerate

  // Channel select for reads; unpopulated channel slots read as zero
  always_comb begin
    rd_mux_s = 32'd0;
    if (int'(ch_s) < NUM_CH) rd_mux_s = ch_rdata_s[ch_s];
    else                     rd_mux_s = 32'd0;
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  readdata_r <= 32'd0;
    else if (chipselect && read) readdata_r <= rd_mux_s;
  end

  assign readdata = readdata_r;
  assign irq      = |irq_req_s;

endmodule

// File: tb/tb_avalon_timer_mc.sv
// Directed self-checking bench for avalon_timer_mc (default build; prescaler test under macro).
module tb_avalon_timer_mc;
  import avalon_timer_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              chipselect, write, read;
  logic [AW-1:0]     address;
  logic [31:0]       writedata, readdata;
  logic              irq;
  logic [NUM_CH-1:0] out_th;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;
  int n;

  always #5 clk = ~clk;

  avalon_timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chipselect (chipselect),
    .address    (address),
    .write      (write),
    .read       (read),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_th     (out_th)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write is sampled at the next posedge
  task automatic wr(input logic [1:0] ch, input logic [1:0] r, input logic [31:0] v);
    chipselect = 1'b1; write = 1'b1; address = {ch, r}; writedata = v;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] ch, input logic [1:0] r, output logic [31:0] v);
    chipselect = 1'b1; read = 1'b1; address = {ch, r};
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    v = readdata;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] ch, input logic [1:0] r,
                       input logic [31:0] exp);
    logic [31:0] v;
    rd(ch, r, v);
    check(tag, v, exp);
  endtask

  task automatic count_hi(output int hi);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_th[2]) hi++;
    end
  endtask

  initial begin
    rst_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 4'd0; writedata = 32'd0;
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_out_th", {28'd0, out_th}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rdchk("rst_load0", 2'd0, REG_LOAD, 32'd0);
    rdchk("rst_ctrl0", 2'd0, REG_CTRL, 32'd0);

    // periodic: read k returns COUNT after write edge + (k-1)
    wr(2'd0, REG_LOAD, 32'd4);
    wr(2'd0, REG_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      rd(2'd0, REG_COUNT, d);
      check("per_cnt", d, 32'((k - 1) % 5));
      check("per_irq", {31'd0, irq}, (k >= 5) ? 32'd1 : 32'd0);
    end
    rdchk("per_ctrl", 2'd0, REG_CTRL, 32'hB);
    wr(2'd0, REG_CTRL, 32'hB);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    wr(2'd0, REG_CTRL, 32'h2);
    check("stop_irq", {31'd0, irq}, 32'd0);

    // oneshot on ch1
    wr(2'd1, REG_LOAD, 32'd3);
    wr(2'd1, REG_CTRL, 32'h5);
    repeat (6) @(negedge clk);
    rdchk("one_cnt", 2'd1, REG_COUNT, 32'd3);
    rdchk("one_ctrl", 2'd1, REG_CTRL, 32'h6);
    check("one_irq", {31'd0, irq}, 32'd0);
    rdchk("indep_cnt0", 2'd0, REG_COUNT, 32'd4);

    // LOAD=0 periodic: COUNT stays 0, pending every tick
    wr(2'd1, REG_LOAD, 32'd0);
    wr(2'd1, REG_COUNT, 32'd0);
    wr(2'd1, REG_CTRL, 32'h3);
    rdchk("ld0_cnt_a", 2'd1, REG_COUNT, 32'd0);
    rdchk("ld0_cnt_b", 2'd1, REG_COUNT, 32'd0);
    rdchk("ld0_ctrl", 2'd1, REG_CTRL, 32'h3);
    wr(2'd1, REG_CTRL, 32'h0);

    // PWM on ch2: 3 of every 10 cycles high
    wr(2'd2, REG_LOAD, 32'd9);
    wr(2'd2, REG_THRESH, 32'd3);
    wr(2'd2, REG_CTRL, 32'h1);
    repeat (3) @(negedge clk);
    count_hi(n);
    check("pwm_th3", n, 32'd6);
    wr(2'd2, REG_THRESH, 32'd0);
    repeat (2) @(negedge clk);
    count_hi(n);
    check("pwm_th0", n, 32'd0);
    wr(2'd2, REG_THRESH, 32'd10);
    repeat (2) @(negedge clk);
    count_hi(n);
    check("pwm_th10", n, 32'd20);
    wr(2'd2, REG_CTRL, 32'h0);
    repeat (2) @(negedge clk);
    check("pwm_dis", {31'd0, out_th[2]}, 32'd0);

    // collisions on ch3 (LOAD=2 wraps on write edge +3 and +6)
    wr(2'd3, REG_LOAD, 32'd2);
    wr(2'd3, REG_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    wr(2'd3, REG_CTRL, 32'h3);
    rdchk("col_w1c", 2'd3, REG_CTRL, 32'h3);
    @(negedge clk);
    wr(2'd3, REG_COUNT, 32'd7);
    rdchk("col_cnt", 2'd3, REG_COUNT, 32'd7);
    wr(2'd3, REG_CTRL, 32'h2);
    rdchk("indep_ld2", 2'd2, REG_LOAD, 32'd9);

`ifdef AVALON_TIMER_PRESCALER_EN
    wr(2'd0, REG_LOAD, 32'd1);
    wr(2'd0, REG_COUNT, 32'd0);
    wr(2'd0, REG_CTRL, 32'h201);
    rdchk("ps_cnt1", 2'd0, REG_COUNT, 32'd0);
    rdchk("ps_cnt2", 2'd0, REG_COUNT, 32'd0);
    rdchk("ps_cnt3", 2'd0, REG_COUNT, 32'd0);
    rdchk("ps_cnt4", 2'd0, REG_COUNT, 32'd1);
    repeat (2) @(negedge clk);
    rdchk("ps_pend", 2'd0, REG_CTRL, 32'h203);
    wr(2'd0, REG_CTRL, 32'h2);
`else
    wr(2'd0, REG_CTRL, 32'hFFFF_FF00);
    rdchk("ps_off", 2'd0, REG_CTRL, 32'd0);
`endif

    // async reset mid-count with irq and out_th high
    wr(2'd2, REG_CTRL, 32'h9);
    repeat (12) @(negedge clk);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    check("pre_rst_th", {31'd0, out_th[2]}, 32'd1);
    rdchk("pre_rst_ctrl", 2'd2, REG_CTRL, 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq}, 32'd0);
    check("arst_out_th", {28'd0, out_th}, 32'd0);
    check("arst_rdata", readdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rdchk("post_ctrl2", 2'd2, REG_CTRL, 32'd0);
    rdchk("post_load2", 2'd2, REG_LOAD, 32'd0);
    rdchk("post_cnt2", 2'd2, REG_COUNT, 32'd0);
    rdchk("post_ctrl1", 2'd1, REG_CTRL, 32'd0);
    check("post_irq", {31'd0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
